// File: rtl/reg_bank_pkg.sv
// Shared address-map helpers for the 16-bit datapath register bank.
package reg_bank_pkg;

   localparam int unsigned GPR_BASE = 0;

   function automatic int unsigned idx_base(input int unsigned ngpr);
      return GPR_BASE + ngpr;
   endfunction

   // First address past the counters; it and everything above read as zero.
   function automatic int unsigned const_addr(input int unsigned ngpr, input int unsigned nidx);
      return idx_base(ngpr) + nidx;
   endfunction

   function automatic int unsigned calc_aw(input int unsigned ngpr, input int unsigned nidx);
      return (ngpr + nidx + 1 > 1) ? $clog2(ngpr + nidx + 1) : 1;
   endfunction

endpackage

// File: rtl/idx_counter.sv
// Loop-index counter: bus load, decrement to zero with done pulse, optional reload.
module idx_counter #(
   parameter int unsigned      WIDTH  = 16,
   parameter logic [WIDTH-1:0] INIT   = '0,
   parameter bit               RELOAD = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ld_i,
   input  logic             dec_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] cnt_d_o,
   output logic [WIDTH-1:0] cnt_q_o,
   output logic             zero_o,
   output logic             done_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (ld_i) begin
         cnt_d = data_i;
      end else if (dec_i) begin
         if (cnt_q > WIDTH'(1)) begin
            cnt_d = cnt_q - WIDTH'(1);
         end else if (cnt_q == WIDTH'(1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else if (RELOAD) begin
            cnt_d = INIT;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= INIT;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt_d_o = cnt_d;
   assign cnt_q_o = cnt_q;
   assign zero_o  = (cnt_q == '0);
   assign done_o  = done_q;

endmodule

// File: rtl/reg_bank.sv
// Register bank: bus-loaded GPRs, index counters and two registered read ports.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int unsigned             WIDTH    = 16,
   parameter int unsigned             NGPR     = 4,
   parameter int unsigned             NIDX     = 2,
   parameter logic [NIDX*WIDTH-1:0]   IDX_INIT = {16'd100, 16'd10},
   parameter bit                      RELOAD   = 1'b0,
   parameter int unsigned             AW       = calc_aw(NGPR, NIDX)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [WIDTH-1:0]       bus_i,
   input  logic [NGPR-1:0]        ld_i,
   input  logic [NIDX-1:0]        idx_ld_i,
   input  logic [NIDX-1:0]        idx_dec_i,
   input  logic [AW-1:0]          rd_sel_a_i,
   input  logic [AW-1:0]          rd_sel_b_i,
   output logic [WIDTH-1:0]       rd_a_o,
   output logic [WIDTH-1:0]       rd_b_o,
   output logic [NGPR*WIDTH-1:0]  gpr_q_o,
   output logic [NIDX*WIDTH-1:0]  idx_q_o,
   output logic [NIDX-1:0]        idx_zero_o,
   output logic [NIDX-1:0]        idx_done_o
);

   localparam int unsigned IdxBase   = idx_base(NGPR);
   localparam int unsigned ConstAddr = const_addr(NGPR, NIDX);

   logic [NGPR*WIDTH-1:0] gpr_q, gpr_d;
   logic [NIDX*WIDTH-1:0] idx_d;
   logic [WIDTH-1:0]      rd_a_q, rd_a_d, rd_b_q, rd_b_d;

   always_comb begin
      gpr_d = gpr_q;
      for (int unsigned k = 0; k < NGPR; k++) begin
         if (ld_i[k]) begin
            gpr_d[k*WIDTH +: WIDTH] = bus_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gpr_q <= '0;
      end else begin
         gpr_q <= gpr_d;
      end
   end

   for (genvar g = 0; g < NIDX; g++) begin : g_idx
      idx_counter #(
         .WIDTH  (WIDTH),
         .INIT   (IDX_INIT[g*WIDTH +: WIDTH]),
         .RELOAD (RELOAD)
      ) u_idx (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .ld_i    (idx_ld_i[g]),
         .dec_i   (idx_dec_i[g]),
         .data_i  (bus_i),
         .cnt_d_o (idx_d[g*WIDTH +: WIDTH]),
         .cnt_q_o (idx_q_o[g*WIDTH +: WIDTH]),
         .zero_o  (idx_zero_o[g]),
         .done_o  (idx_done_o[g])
      );
   end

   // Muxing next-state values gives same-edge write bypass for free.
   function automatic logic [WIDTH-1:0] rd_mux(input logic [AW-1:0]         sel,
                                               input logic [NGPR*WIDTH-1:0] gpr,
                                               input logic [NIDX*WIDTH-1:0] idx);
      logic [WIDTH-1:0] val;
      val = '0;
      if (32'(sel) < ConstAddr) begin
         for (int unsigned k = 0; k < NGPR; k++) begin
            if (32'(sel) == GPR_BASE + k) val = gpr[k*WIDTH +: WIDTH];
         end
         for (int unsigned k = 0; k < NIDX; k++) begin
            if (32'(sel) == IdxBase + k) val = idx[k*WIDTH +: WIDTH];
         end
      end
      return val;
   endfunction

   always_comb begin
      rd_a_d = rd_mux(rd_sel_a_i, gpr_d, idx_d);
      rd_b_d = rd_mux(rd_sel_b_i, gpr_d, idx_d);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign gpr_q_o = gpr_q;
   assign rd_a_o  = rd_a_q;
   assign rd_b_o  = rd_b_q;

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank for the 16-bit datapath. It holds a set of general registers loaded from the shared bus, plus a set of loop-index counters with load, decrement, zero detection and optional auto-reload. Two registered read ports select any register, or the constant zero, onto the ALU operand lines. It replaces the fixed four-temp / two-index / const arrangement and sits between the bus and the ALU input muxes.

## Interface
- WIDTH, 16, data width of every register
- NGPR, 4, number of general registers
- NIDX, 2, number of index counters
- IDX_INIT, {16'd100, 16'd10}, packed NIDX*WIDTH reset/reload values; slice k initialises index k
- RELOAD, 0, 1 = a decrement at zero reloads IDX_INIT; 0 = the counter holds at zero
- AW, $clog2(NGPR+NIDX+1), read-select width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- bus  in  WIDTH  write data
- ld  in  NGPR  per-GPR load enable; several may be high at once, and all selected registers load
- idx_ld  in  NIDX  per-index load from bus
- idx_dec  in  NIDX  per-index decrement
- rd_sel_a, rd_sel_b  in  AW  read select
- rd_a, rd_b  out  WIDTH  registered read data
- gpr_q  out  NGPR*WIDTH  flat GPR contents; GPR k is at [k*WIDTH +: WIDTH]
- idx_q  out  NIDX*WIDTH  flat index contents
- idx_zero  out  NIDX  combinational, value == 0
- idx_done  out  NIDX  registered one-cycle pulse when a decrement brings the counter from 1 to 0

## Operation
- Address map:
  - 0..NGPR-1: GPR
  - NGPR..NGPR+NIDX-1: index counters
  - NGPR+NIDX: constant zero
  - higher: zero
- GPR k: on a clock edge with ld[k]=1, loads bus; otherwise holds.
- Index k, priority order:
  - idx_ld: loads bus. idx_dec in the same cycle is ignored and idx_done stays 0.
  - else idx_dec with value > 1: decrement by 1.
  - value == 1: set to 0 and pulse idx_done.
  - value == 0: reload IDX_INIT if RELOAD=1, else hold. No done pulse in either case.
  - else hold.
- Arithmetic is unsigned, WIDTH bits. No wrap below zero is ever possible.
- Read ports:
  - rd_x <= selected value at each edge.
  - Write bypass: if the selected GPR or index is being updated on the same edge, rd_x takes the new value, not the old one.
  - Ports are independent; both may select the same register.

## Timing
- Reset (rst=0, asynchronous):
  - gpr_q all 0
  - idx_q = IDX_INIT
  - rd_a = rd_b = 0
  - idx_done = 0
- Outputs immediately after reset: idx_zero reflects IDX_INIT, so with the defaults it is 0.
- Reset deassertion is synchronised externally; the first functional edge is the first edge with rst=1.
- Reset asserted mid-operation: all state returns to reset values immediately; any pending load or decrement is lost.
- Load latency: ld/idx_ld at edge N gives gpr_q/idx_q updated after edge N.
- Read latency: 1 cycle. rd_sel at edge N gives rd_x valid after edge N, bypass included.
- idx_done is high for exactly the cycle after the 1→0 edge and is cleared by any following edge.
- idx_zero follows idx_q with no register stage.

## Structure
- Package reg_bank_pkg holds:
  - the address-map localparams (GPR_BASE, IDX_BASE, CONST_ADDR)
  - the function computing AW from NGPR/NIDX
- Sub-module idx_counter (params WIDTH, INIT, RELOAD): one counter with load/dec/zero/done, instantiated NIDX times via generate.
- GPRs and read muxes stay in the top module. The bypass logic is computed from the next-state values.

## Test plan
- Reset:
  - assert rst=0 asynchronously mid-cycle → gpr_q=0, idx_q={100,10}, rd_a=rd_b=0, idx_done=0 without waiting for a clock edge.
- GPR load and read:
  - ld=4'b0101, bus=16'hBEEF for one cycle → GPR0 and GPR2 hold BEEF, GPR1 and GPR3 hold 0.
  - rd_sel_a=2 → rd_a=BEEF one cycle later.
- Bypass:
  - same cycle: ld[1]=1, bus=16'h1234, rd_sel_b=1 → rd_b=1234 after that edge.
  - rd_sel_a=6 (const) → rd_a=0.
- Index countdown:
  - idx_dec[0] held high from reset → idx_q0 counts 10…1,0.
  - idx_done[0] pulses once, on the cycle after reaching 0; idx_zero[0]=1 from then on.
  - RELOAD=0: value stays 0. RELOAD=1: the next decrement gives 10 and no pulse.
- Load priority:
  - idx_ld[1]=1 and idx_dec[1]=1 together, bus=3 → idx_q1=3, no decrement, no idx_done.
- Reset during countdown:
  - idx_q0=1 with idx_dec asserted, rst dropped before the edge → idx_q0=10, idx_done stays 0.
